// File: rtl/bram_stream_reader.sv
// Streams a contiguous block of BRAM words (Port B, 1-cycle read latency) out over AXI4-Stream.
// Optional start-to-first-beat / start-to-done cycle counters: define STREAM_CYCLE_COUNT_EN.
module bram_stream_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 11
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en_b,
    output logic [ADDR_WIDTH-1:0] bram_addr_b,
    input  logic [DATA_WIDTH-1:0] bram_rdata_b,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           first_lat,
    output logic [15:0]           total_cyc
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_last_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            buf_count_q;
    logic                  busy_q;
    logic                  done_q;

    logic       pop;
    logic       push;
    logic [2:0] occ_after;
    logic       issue_ok;
    logic       issue;
    logic       last_issue;
    logic       drain_empty;

    always_comb begin
        pop         = m_axis_tvalid & m_axis_tready;
        push        = inflight_q;
        // Slots committed after this edge; a read may only be issued if it has a home.
        occ_after   = 3'(buf_count_q) + 3'(inflight_q) - 3'(pop);
        issue_ok    = occ_after < 3'd2;
        issue       = (state_q == StRun) && issue_ok;
        last_issue  = issue && (remaining_q == LEN_WIDTH'(1));
        // Buffer will be empty after this edge with nothing left in the BRAM pipe.
        drain_empty = !inflight_q &&
                      ((buf_count_q == 2'd0) || ((buf_count_q == 2'd1) && pop));
    end

    assign bram_en_b     = issue;
    assign bram_addr_b   = addr_q;
    assign m_axis_tvalid = buf_count_q != 2'd0;
    assign m_axis_tdata  = buf_data_q[rd_ptr_q];
    assign m_axis_tlast  = m_axis_tvalid & buf_last_q[rd_ptr_q];
    assign busy          = busy_q;
    assign done          = done_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            buf_count_q     <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= last_issue;

            if (push) begin
                buf_data_q[wr_ptr_q] <= bram_rdata_b;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_count_q <= buf_count_q + 2'(push) - 2'(pop);

            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= length;
                        busy_q      <= 1'b1;
                        if (length == '0) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        addr_q      <= addr_q + ADDR_WIDTH'(1);
                        remaining_q <= remaining_q - LEN_WIDTH'(1);
                        if (last_issue) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_empty) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef STREAM_CYCLE_COUNT_EN
    logic [15:0] cyc_q;
    logic [15:0] cyc_inc;
    logic [15:0] first_lat_q;
    logic [15:0] total_cyc_q;
    logic        first_seen_q;

    // Value latched is the cycle count including the cycle the event occurs in.
    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;

    always_ff @(posedge aclk) begin
        if (areset) begin
            cyc_q        <= '0;
            first_lat_q  <= '0;
            total_cyc_q  <= '0;
            first_seen_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            cyc_q        <= '0;
            first_lat_q  <= '0;
            total_cyc_q  <= '0;
            first_seen_q <= 1'b0;
        end else begin
            if (busy_q) begin
                cyc_q <= cyc_inc;
            end
            if (push && !first_seen_q) begin
                first_lat_q  <= cyc_inc;
                first_seen_q <= 1'b1;
            end
            if (state_q == StDone) begin
                total_cyc_q <= cyc_inc;
            end
        end
    end

    assign first_lat = first_lat_q;
    assign total_cyc = total_cyc_q;
`else
    assign first_lat = 16'd0;
    assign total_cyc = 16'd0;
`endif

endmodule
